// File: rtl/mips_defines.sv
// Shared encodings for the HI/LO multiply/divide unit.
// Operation codes, FSM states and a magnitude helper.
package mips_defines;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } md_state_e;

    localparam logic [4:0] LAST_STEP = 5'd31;

    // Absolute value when the operation treats x as signed.
    function automatic logic [31:0] mag(input logic [31:0] x,
                                        input logic        sgn);
        return (sgn && x[31]) ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or
// restoring shift-subtract divide on {a,b} with operand m.
module muldiv_step (
    input  logic        is_div_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] m_i,
    output logic [31:0] a_o,
    output logic [31:0] b_o
);

    logic [32:0] sum;
    logic [32:0] sh;
    logic [31:0] diff;

    // Single iteration; remainder stays below m so 32 bits hold it.
    always_comb begin
        sum  = {1'b0, a_i} + (b_i[0] ? {1'b0, m_i} : 33'd0);
        sh   = {a_i, b_i[31]};
        diff = sh[31:0] - m_i;
        if (is_div_i) begin
            if (sh >= {1'b0, m_i}) begin
                a_o = diff;
                b_o = {b_i[30:0], 1'b1};
            end else begin
                a_o = sh[31:0];
                b_o = {b_i[30:0], 1'b0};
            end
        end else begin
            a_o = sum[32:1];
            b_o = {sum[0], b_i[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU controller with HI/LO.
// 32 steps in RUN, sign fix and HI/LO write in FIX.
module muldiv_ctrl
    import mips_defines::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        mf_req,
    input  logic        mf_sel,
    output logic [31:0] mf_data,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e   state_q, state_d;
    md_op_e      op_q, op_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] m_q, m_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic        div0_q, div0_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        is_div;
    logic        sgn_op;
    logic [31:0] step_a;
    logic [31:0] step_b;
    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;

    assign is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);
    assign sgn_op = (md_op == OP_MULT) || (md_op == OP_DIV);

    muldiv_step u_step (
        .is_div_i (is_div),
        .a_i      (a_q),
        .b_i      (b_q),
        .m_i      (m_q),
        .a_o      (step_a),
        .b_o      (step_b)
    );

    // Sign-corrected results presented to the FIX write.
    always_comb begin
        prod = {a_q, b_q};
        if (neg_res_q) prod = ~prod + 64'd1;
        quo = neg_res_q ? (~b_q + 32'd1) : b_q;
        rem = neg_rem_q ? (~a_q + 32'd1) : a_q;
    end

    // Next state, datapath and HI/LO update; start always restarts.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        m_d       = m_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (start) begin
            state_d   = S_RUN;
            op_d      = md_op_e'(md_op);
            cnt_d     = 5'd0;
            a_d       = 32'd0;
            b_d       = mag(rs_data, sgn_op);
            m_d       = mag(rt_data, sgn_op);
            neg_res_d = sgn_op && (rs_data[31] ^ rt_data[31]);
            neg_rem_d = sgn_op && rs_data[31];
            div0_d    = (rt_data == 32'd0);
            busy_d    = 1'b1;
        end else begin
            unique case (state_q)
                S_RUN: begin
                    a_d   = step_a;
                    b_d   = step_b;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == LAST_STEP) state_d = S_FIX;
                end
                S_FIX: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (is_div) begin
                        lo_d = div0_q ? 32'hFFFF_FFFF : quo;
                        hi_d = rem;
                    end else begin
                        lo_d = prod[31:0];
                        hi_d = prod[63:32];
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers; reset discards any operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= OP_MULT;
            cnt_q     <= 5'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            m_q       <= 32'd0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            m_q       <= m_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign mf_data = mf_sel ? hi_q : lo_q;
    assign stall   = mf_req && (start || busy_q);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: vector table plus
// hand sequences for stall, abort, FIX restart and reset.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  md_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        mf_req;
    logic        mf_sel;
    logic [31:0] mf_data;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    localparam int NV = 13;
    vec_t vec [NV];

    muldiv_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .md_op   (md_op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .mf_req  (mf_req),
        .mf_sel  (mf_sel),
        .mf_data (mf_data),
        .stall   (stall),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives start for one cycle (cycle 0); returns in cycle 1.
    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        start   = 1'b1;
        md_op   = op;
        rs_data = a;
        rt_data = b;
        step(1);
        start   = 1'b0;
    endtask

    initial begin
        vec[0]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vec[1]  = '{2'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
        vec[2]  = '{2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vec[3]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vec[4]  = '{2'd3, 32'd100,      32'd7,        32'd2,        32'd14};
        vec[5]  = '{2'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vec[6]  = '{2'd2, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
        vec[7]  = '{2'd2, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
        vec[8]  = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vec[9]  = '{2'd1, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780};
        vec[10] = '{2'd3, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF};
        vec[11] = '{2'd0, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
        vec[12] = '{2'd1, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000};

        rst = 1'b1;
        start = 1'b0;
        md_op = 2'd0;
        rs_data = 32'd0;
        rt_data = 32'd0;
        mf_req = 1'b1;
        mf_sel = 1'b0;
        step(3);
        rst = 1'b0;
        step(1);

        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("idle_stall", {31'd0, stall}, 32'd0);
        mf_req = 1'b0;

        for (int i = 0; i < NV; i++) begin
            issue(vec[i].op, vec[i].rs, vec[i].rt);
            check($sformatf("v%0d_busy1", i), {31'd0, busy}, 32'd1);
            step(32);
            check($sformatf("v%0d_busy33", i), {31'd0, busy}, 32'd1);
            check($sformatf("v%0d_nodone33", i), {31'd0, done}, 32'd0);
            step(1);
            check($sformatf("v%0d_busy34", i), {31'd0, busy}, 32'd0);
            check($sformatf("v%0d_done34", i), {31'd0, done}, 32'd1);
            check($sformatf("v%0d_hi", i), hi, vec[i].exp_hi);
            check($sformatf("v%0d_lo", i), lo, vec[i].exp_lo);
            step(1);
            check($sformatf("v%0d_done35", i), {31'd0, done}, 32'd0);
        end

        // DIVU 7/0 with MFLO waiting in decode from cycle 0.
        mf_req  = 1'b1;
        mf_sel  = 1'b0;
        start   = 1'b1;
        md_op   = 2'd3;
        rs_data = 32'd7;
        rt_data = 32'd0;
        #1;
        check("stall_c0", {31'd0, stall}, 32'd1);
        step(1);
        start = 1'b0;
        for (int c = 1; c <= 33; c++) begin
            check($sformatf("stall_c%0d", c), {31'd0, stall}, 32'd1);
            step(1);
        end
        check("stall_c34", {31'd0, stall}, 32'd0);
        check("div0_mflo", mf_data, 32'hFFFFFFFF);
        mf_sel = 1'b1;
        #1;
        check("div0_mfhi", mf_data, 32'd7);
        mf_req = 1'b0;
        step(2);

        // Abort: MULTU 2x3 then DIVU 100/7 at cycle 5.
        issue(2'd1, 32'd2, 32'd3);
        step(4);
        issue(2'd3, 32'd100, 32'd7);
        step(28);
        check("abort_nodone34", {31'd0, done}, 32'd0);
        check("abort_hi34", hi, 32'd7);
        check("abort_lo34", lo, 32'hFFFFFFFF);
        step(5);
        check("abort_done39", {31'd0, done}, 32'd1);
        check("abort_lo39", lo, 32'd14);
        check("abort_hi39", hi, 32'd2);
        step(2);

        // Restart in FIX: MULTU 3x3 replaced by DIVU 9/2.
        issue(2'd1, 32'd3, 32'd3);
        step(32);
        check("fix_busy33", {31'd0, busy}, 32'd1);
        issue(2'd3, 32'd9, 32'd2);
        check("fix_nodone", {31'd0, done}, 32'd0);
        check("fix_lo_hold", lo, 32'd14);
        check("fix_hi_hold", hi, 32'd2);
        step(33);
        check("fix_done", {31'd0, done}, 32'd1);
        check("fix_lo", lo, 32'd4);
        check("fix_hi", hi, 32'd1);
        step(2);

        // Reset pulse at cycle 10 of MULT -3 x 7.
        issue(2'd0, 32'hFFFFFFFD, 32'd7);
        step(9);
        #2;
        rst = 1'b1;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        step(1);
        rst = 1'b0;
        step(30);
        check("rst_nowrite_lo", lo, 32'd0);
        check("rst_nowrite_hi", hi, 32'd0);
        check("rst_nodone", {31'd0, done}, 32'd0);
        issue(2'd1, 32'd5, 32'd6);
        step(33);
        check("post_rst_done", {31'd0, done}, 32'd1);
        check("post_rst_lo", lo, 32'd30);
        check("post_rst_hi", hi, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
